cordic_vectoring_fixed: RTL and testbench

//  Iterative fixed-point CORDIC in vectoring mode: drives (x_in,y_in) onto the +x axis, producing the

---
 rtl/cordic_pkg.sv | 44 ++++
 rtl/fixed_round_sat.sv | 42 ++++
 rtl/cordic_vectoring_fixed.sv | 216 +++++++++++++++++++++
 tb/tb_cordic_vectoring_fixed.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
//   Constants and types shared by the CORDIC vectoring and rotation stages.
//   - ATAN_TABLE[i] = atan(2^-i), i = 0..23, signed, ATAN_F (24) fraction bits
//   - PI_F24        = pi at ATAN_F fraction bits
//   - INV_K         = 1/K = 0.607253 at INV_K_F fraction bits (gain compensation)
//   - cordic_state_t: IDLE / PRE / ITER / OUT state encoding
//   - scale_f24()   : re-express an ATAN_F-fraction constant at another fraction
// -----------------------------------------------------------------------------
package cordic_pkg;

  localparam int ATAN_F  = 24;
  localparam int INV_K_F = 24;

  localparam logic signed [31:0] ATAN_TABLE [0:23] = '{
    32'sd13176795, 32'sd7778716, 32'sd4110060, 32'sd2086331,
    32'sd1047214,  32'sd524117,  32'sd262123,  32'sd131069,
    32'sd65536,    32'sd32768,   32'sd16384,   32'sd8192,
    32'sd4096,     32'sd2048,    32'sd1024,    32'sd512,
    32'sd256,      32'sd128,     32'sd64,      32'sd32,
    32'sd16,       32'sd8,       32'sd4,       32'sd2
  };

  localparam logic signed [31:0] PI_F24 = 32'sd52707179;
  localparam logic signed [31:0] INV_K  = 32'sd10188014;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ITER = 2'd2,
    OUT  = 2'd3
  } cordic_state_t;

  // Rescale a constant held at ATAN_F fraction bits to 'frac' fraction bits.
  function automatic logic signed [63:0] scale_f24(input logic signed [31:0] v,
                                                   input int frac);
    logic signed [63:0] t;
    t = 64'(v);
    if (frac >= ATAN_F) t = t <<< (frac - ATAN_F);
    else                t = t >>> (ATAN_F - frac);
    return t;
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// -----------------------------------------------------------------------------
// fixed_round_sat
//   Combinational fixed-point narrowing: round-half-up from IN_F to OUT_F
//   fraction bits, then saturate to the signed OUT_W range.
//   Requires IN_F >= OUT_F.
// Ports
//   din   in   IN_W    signed input, IN_F fraction bits
//   dout  out  OUT_W   signed output, OUT_F fraction bits, saturated
// -----------------------------------------------------------------------------
module fixed_round_sat #(
  parameter int IN_W  = 32,
  parameter int IN_F  = 24,
  parameter int OUT_W = 16,
  parameter int OUT_F = 12
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  localparam int SH  = IN_F - OUT_F;
  localparam int HSH = (SH > 0) ? SH - 1 : 0;

  localparam logic signed [IN_W:0] ONE  = (IN_W+1)'(1);
  localparam logic signed [IN_W:0] HALF = (SH > 0) ? (ONE <<< HSH) : '0;
  localparam logic signed [IN_W:0] MAXV = (ONE <<< (OUT_W - 1)) - ONE;
  localparam logic signed [IN_W:0] MINV = -(ONE <<< (OUT_W - 1));

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shr;

  // One extra headroom bit keeps the rounding add from wrapping.
  always_comb begin
    ext = {din[IN_W-1], din};
    sum = ext + HALF;
    shr = sum >>> SH;
    if (shr > MAXV)      dout = MAXV[OUT_W-1:0];
    else if (shr < MINV) dout = MINV[OUT_W-1:0];
    else                 dout = shr[OUT_W-1:0];
  end

endmodule

// File: rtl/cordic_vectoring_fixed.sv
// -----------------------------------------------------------------------------
// cordic_vectoring_fixed
//   Iterative fixed-point CORDIC, vectoring mode. Rotates (x_in, y_in) onto the
//   +x axis one micro-rotation per clock and reports the angle (atan2) and the
//   magnitude. Sequence: IDLE -> PRE (quadrant fold) -> ITER (N cycles) -> OUT.
//   Result appears with a one-cycle done pulse N+2 cycles after valid is taken.
//
// Optional feature macro: GAIN_COMP_EN
//   defined   : mag_out = |v| (x scaled by 1/K before rounding)
//   undefined : mag_out = K*|v|, K ~ 1.646760
//
// Ports
//   clk        in   1           rising-edge clock
//   rst        in   1           asynchronous, active-high reset
//   valid      in   1           input strobe, accepted only in IDLE
//   x_in       in   wordLength  vector x component, two's complement
//   y_in       in   wordLength  vector y component, two's complement
//   theta_out  out  wordLength  atan2(y_in, x_in), radians, in [-pi, +pi]
//   mag_out    out  wordLength  vector magnitude (gain per GAIN_COMP_EN), saturated
//   done       out  1           one-cycle pulse when theta_out/mag_out update
//   busy       out  1           high in PRE and ITER
// -----------------------------------------------------------------------------
module cordic_vectoring_fixed
  import cordic_pkg::*;
#(
  parameter int N              = 15,
  parameter int wordLength     = 16,
  parameter int fractionLength = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [wordLength-1:0] x_in,
  input  logic [wordLength-1:0] y_in,
  output logic [wordLength-1:0] theta_out,
  output logic [wordLength-1:0] mag_out,
  output logic                  done,
  output logic                  busy
);

  localparam int W2 = 2 * wordLength;
  localparam int F2 = 2 * fractionLength;

  localparam logic [4:0] LAST = 5'(N - 1);
  localparam logic signed [W2-1:0] PI_S = W2'(scale_f24(PI_F24, F2));

  cordic_state_t state;
  cordic_state_t state_nxt;

  logic load;
  logic fold;
  logic step;
  logic emit;

  logic signed [W2-1:0] x_p0;
  logic signed [W2-1:0] y_p0;
  logic signed [W2-1:0] z_p0;
  logic [4:0]           iter;
  logic                 zero_in;

  logic signed [W2-1:0] x_ext;
  logic signed [W2-1:0] y_ext;
  logic signed [W2-1:0] x_sh;
  logic signed [W2-1:0] y_sh;
  logic signed [W2-1:0] atan_i;
  logic [4:0]           atan_idx;
  logic                 d;

  logic signed [W2-1:0]   z_clamp;
  logic [wordLength-1:0]  theta_rs;
  logic [wordLength-1:0]  mag_rs;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid) state_nxt = PRE;
      PRE:     state_nxt = ITER;
      ITER:    if (iter == LAST) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: control decode
  always_comb begin
    load = 1'b0;
    fold = 1'b0;
    step = 1'b0;
    emit = 1'b0;
    case (state)
      IDLE:    load = valid;
      PRE:     fold = 1'b1;
      ITER:    step = 1'b1;
      OUT:     emit = 1'b1;
      default: ;
    endcase
    busy = fold | step;
  end

  // ---------------------------------------------------------------------------
  // Working stage: load / quadrant fold / micro-rotations
  // ---------------------------------------------------------------------------
  // Inputs are widened and moved up so the working fraction is F2 bits.
  assign x_ext = {{wordLength{x_in[wordLength-1]}}, x_in} <<< fractionLength;
  assign y_ext = {{wordLength{y_in[wordLength-1]}}, y_in} <<< fractionLength;

  assign x_sh     = x_p0 >>> iter;
  assign y_sh     = y_p0 >>> iter;
  assign atan_idx = (iter > 5'd23) ? 5'd23 : iter;
  assign atan_i   = W2'(scale_f24(ATAN_TABLE[atan_idx], F2));
  assign d        = ~y_p0[W2-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_p0    <= '0;
      y_p0    <= '0;
      z_p0    <= '0;
      iter    <= '0;
      zero_in <= 1'b0;
    end else begin
      if (load) begin
        x_p0    <= x_ext;
        y_p0    <= y_ext;
        z_p0    <= '0;
        iter    <= '0;
        zero_in <= (x_in == '0) && (y_in == '0);
      end else if (fold) begin
        // Left half-plane: rotate by pi so the iterations only see |angle| <= pi/2.
        if (x_p0 < 0) begin
          x_p0 <= -x_p0;
          y_p0 <= -y_p0;
          z_p0 <= (y_p0 >= 0) ? PI_S : -PI_S;
        end
        iter <= '0;
      end else if (step) begin
        // Both updates use the previous-cycle x and y.
        x_p0 <= d ? (x_p0 + y_sh) : (x_p0 - y_sh);
        y_p0 <= d ? (y_p0 - x_sh) : (y_p0 + x_sh);
        z_p0 <= d ? (z_p0 + atan_i) : (z_p0 - atan_i);
        iter <= iter + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: clamp, gain, round + saturate, register
  // ---------------------------------------------------------------------------
  // A zero vector would otherwise accumulate the full atan sum; the residual
  // of the last micro-rotation can also push the angle just past +-pi.
  always_comb begin
    z_clamp = z_p0;
    if (zero_in)           z_clamp = '0;
    else if (z_p0 > PI_S)  z_clamp = PI_S;
    else if (z_p0 < -PI_S) z_clamp = -PI_S;
  end

  fixed_round_sat #(
    .IN_W (W2),
    .IN_F (F2),
    .OUT_W(wordLength),
    .OUT_F(fractionLength)
  ) u_theta_rs (
    .din (z_clamp),
    .dout(theta_rs)
  );

`ifdef GAIN_COMP_EN
  logic signed [W2+31:0] mag_pre;

  assign mag_pre = (W2+32)'(x_p0) * (W2+32)'(INV_K);

  fixed_round_sat #(
    .IN_W (W2 + 32),
    .IN_F (F2 + INV_K_F),
    .OUT_W(wordLength),
    .OUT_F(fractionLength)
  ) u_mag_rs (
    .din (mag_pre),
    .dout(mag_rs)
  );
`else
  fixed_round_sat #(
    .IN_W (W2),
    .IN_F (F2),
    .OUT_W(wordLength),
    .OUT_F(fractionLength)
  ) u_mag_rs (
    .din (x_p0),
    .dout(mag_rs)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      theta_out <= '0;
      mag_out   <= '0;
      done      <= 1'b0;
    end else begin
      done <= emit;
      if (emit) begin
        theta_out <= theta_rs;
        mag_out   <= mag_rs;
      end
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_fixed.sv
// -----------------------------------------------------------------------------
// tb_cordic_vectoring_fixed
//   Self-checking bench for cordic_vectoring_fixed at Q4.12, N = 15.
//   Directed vector table, random vectors against a real-arithmetic
//   atan2/sqrt reference, and hand-written reset / handshake sequences.
//   Honours GAIN_COMP_EN for the expected magnitude gain.
// -----------------------------------------------------------------------------
module tb_cordic_vectoring_fixed;

  localparam int NIT = 15;
  localparam int TOL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [15:0] theta_out;
  logic [15:0] mag_out;
  logic        done;
  logic        busy;

  always #5 clk = ~clk;

  cordic_vectoring_fixed #(
    .N(NIT),
    .wordLength(16),
    .fractionLength(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .x_in(x_in),
    .y_in(y_in),
    .theta_out(theta_out),
    .mag_out(mag_out),
    .done(done),
    .busy(busy)
  );

  int  total  = 0;
  int  passed = 0;
  real gain;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] th;
    logic [15:0] mg_raw;
    logic [15:0] mg_comp;
  } vec_t;

  vec_t vecs [0:8];

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string name, input int act, input int exp, input int tol);
    int diff;
    total++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff <= tol) passed++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
  endtask

  function automatic int model_theta(input int xv, input int yv);
    if (xv == 0 && yv == 0) return 0;
    return $rtoi($floor($atan2(real'(yv), real'(xv)) * 4096.0 + 0.5));
  endfunction

  function automatic int model_mag(input int xv, input int yv);
    real m;
    int  r;
    m = gain * $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
    r = $rtoi($floor(m + 0.5));
    if (r > 32767) r = 32767;
    return r;
  endfunction

  // Issue one request and wait (bounded) for done; lat counts clocks from the
  // edge that took valid to the edge that raised done.
  task automatic apply(input logic [15:0] xv, input logic [15:0] yv,
                       output logic [15:0] th, output logic [15:0] mg, output int lat);
    @(negedge clk);
    x_in  = xv;
    y_in  = yv;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    th = theta_out;
    mg = mag_out;
  endtask

  initial begin
    logic [15:0] th;
    logic [15:0] mg;
    logic [15:0] th_hold;
    int          lat;
    int          ndone;
    int          xr;
    int          yr;

    gain = 1.0;
`ifndef GAIN_COMP_EN
    for (int i = 0; i < NIT; i++) gain = gain * $sqrt(1.0 + 1.0 / real'(64'd1 << (2 * i)));
`endif

    //            x         y         theta     mag(K)    mag(1/K comp)
    vecs[0] = '{16'h1000, 16'h0000, 16'h0000, 16'h1A59, 16'h1000};
    vecs[1] = '{16'h1000, 16'h1000, 16'h0C91, 16'h2543, 16'h16A1};
    vecs[2] = '{16'hF000, 16'h0000, 16'h3244, 16'h1A59, 16'h1000};
    vecs[3] = '{16'hF000, 16'hFFFF, 16'hCDBC, 16'h1A59, 16'h1000};
    vecs[4] = '{16'h1000, 16'h3000, 16'h13FC, 16'h5352, 16'h3299};
    vecs[5] = '{16'h7FFF, 16'h7FFF, 16'h0C91, 16'h7FFF, 16'h7FFF};
    vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[7] = '{16'h0000, 16'h1000, 16'h1922, 16'h1A59, 16'h1000};
    vecs[8] = '{16'h0000, 16'hF000, 16'hE6DE, 16'h1A59, 16'h1000};

    rst   = 1'b1;
    valid = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_theta", s16(theta_out), 0, 0);
    check("reset_mag",   s16(mag_out),   0, 0);
    check("reset_done",  int'(done),     0, 0);
    check("reset_busy",  int'(busy),     0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].x, vecs[i].y, th, mg, lat);
      check($sformatf("vec%0d_latency", i), lat, NIT + 2, 0);
      check($sformatf("vec%0d_theta", i), s16(th), s16(vecs[i].th), TOL);
`ifdef GAIN_COMP_EN
      check($sformatf("vec%0d_mag", i), s16(mg), s16(vecs[i].mg_comp), TOL);
`else
      check($sformatf("vec%0d_mag", i), s16(mg), s16(vecs[i].mg_raw), TOL);
`endif
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), int'(done), 0, 0);
    end

    // Busy window and output hold
    apply(16'h1000, 16'h3000, th, mg, lat);
    check("busy_after_done", int'(busy), 0, 0);
    th_hold = theta_out;
    repeat (6) @(posedge clk);
    #1;
    check("theta_hold", s16(theta_out), s16(th_hold), 0);
    check("theta_hold_value", s16(theta_out), 16'sh13FC, TOL);
    @(negedge clk);
    x_in = 16'h1000; y_in = 16'h1000; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    check("busy_in_pre", int'(busy), 1, 0);

    // Second request while busy must be ignored: exactly one done, first result
    repeat (3) @(posedge clk);
    @(negedge clk);
    x_in = 16'h0000; y_in = 16'hF000; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    ndone = 0;
    th = '0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        th = theta_out;
      end
    end
    check("busy_ignore_ndone", ndone, 1, 0);
    check("busy_ignore_theta", s16(th), 16'sh0C91, TOL);

    // Reset five cycles into ITER aborts with no done
    @(negedge clk);
    x_in = 16'h1000; y_in = 16'h3000; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", int'(busy), 1, 0);
    rst = 1'b1;
    #1;
    check("abort_theta", s16(theta_out), 0, 0);
    check("abort_mag",   s16(mag_out),   0, 0);
    check("abort_busy",  int'(busy),     0, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0, 0);

    // Random vectors against the real-arithmetic reference
    for (int i = 0; i < 40; i++) begin
      do begin
        xr = s16(16'($urandom));
        yr = s16(16'($urandom));
      end while (xr * xr + yr * yr < 1024 * 1024);
      apply(16'(xr), 16'(yr), th, mg, lat);
      check($sformatf("rnd%0d_latency", i), lat, NIT + 2, 0);
      check($sformatf("rnd%0d_theta x=%0d y=%0d", i, xr, yr), s16(th), model_theta(xr, yr), TOL);
      check($sformatf("rnd%0d_mag x=%0d y=%0d", i, xr, yr), s16(mg), model_mag(xr, yr), TOL);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
